graph_readout: RTL and testbench

Graph-level readout stage directly downstream of the second MAC layer. It consumes the two 21-bit per-node class scores that layer produces and sum-pools them over a fixed number of nodes per graph. It then emits a two-class decision with the pooled scores on a valid/ack handshake to the host-facing result interface.

---
 rtl/graph_readout_if.sv | 37 +++
 rtl/graph_readout.sv | 140 ++++++++++++++
 tb/tb_graph_readout.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/graph_readout_if.sv
// Result-path bundle for graph_readout: node score inputs,
// abort/ack controls and the pooled decision outputs.
interface graph_readout_if #(
  parameter int IN_W  = 21,
  parameter int ACC_W = 24
);
  logic                    in0_valid;
  logic                    in1_valid;
  logic signed [IN_W-1:0]  in0;
  logic signed [IN_W-1:0]  in1;
  logic                    clr;
  logic                    class_ack;
  logic                    class_valid;
  logic                    class_id;
  logic signed [ACC_W-1:0] score0;
  logic signed [ACC_W-1:0] score1;
  logic                    overrun;
  logic                    err_mismatch;

  modport master (
    output in0_valid, in1_valid,
    output in0, in1,
    output clr, class_ack,
    input  class_valid, class_id,
    input  score0, score1,
    input  overrun, err_mismatch
  );

  modport slave (
    input  in0_valid, in1_valid,
    input  in0, in1,
    input  clr, class_ack,
    output class_valid, class_id,
    output score0, score1,
    output overrun, err_mismatch
  );
endinterface

// File: rtl/graph_readout.sv
// Graph readout: sum-pools two per-node class scores over NUM_NODES
// nodes and holds the decision; READOUT_MEAN_EN selects mean pooling.
module graph_readout #(
  parameter int NUM_NODES = 8,
  parameter int IN_W      = 21,
  parameter int ACC_W     = 24
) (
  input logic             clk,
  input logic             rst_n,
  graph_readout_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_NODES);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  generate
    if (NUM_NODES < 2) begin : g_nn_chk
      $error("NUM_NODES must be >= 2");
    end
    if (ACC_W < IN_W + $clog2(NUM_NODES)) begin : g_w_chk
      $error("ACC_W too narrow");
    end
`ifdef READOUT_MEAN_EN
    if ((NUM_NODES & (NUM_NODES - 1)) != 0) begin : g_p2_chk
      $error("NUM_NODES must be a power of two");
    end
`endif
  endgenerate

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc0;
  logic signed [ACC_W-1:0] acc1;
  logic signed [ACC_W-1:0] sc0;
  logic signed [ACC_W-1:0] sc1;
  logic                    vld;
  logic                    cid;
  logic                    ovr;
  logic                    mis;

  logic                    pair;
  logic                    one;
  logic                    any;
  logic                    last;
  logic signed [ACC_W-1:0] ext0;
  logic signed [ACC_W-1:0] ext1;
  logic signed [ACC_W-1:0] sum0;
  logic signed [ACC_W-1:0] sum1;
  logic signed [ACC_W-1:0] fin0;
  logic signed [ACC_W-1:0] fin1;

  assign pair = bus.in0_valid & bus.in1_valid;
  assign one  = bus.in0_valid ^ bus.in1_valid;
  assign any  = bus.in0_valid | bus.in1_valid;
  assign last = (cnt == CNT_W'(NUM_NODES - 1));

  assign ext0 = {{(ACC_W-IN_W){bus.in0[IN_W-1]}}, bus.in0};
  assign ext1 = {{(ACC_W-IN_W){bus.in1[IN_W-1]}}, bus.in1};
  assign sum0 = acc0 + ext0;
  assign sum1 = acc1 + ext1;

`ifdef READOUT_MEAN_EN
  localparam int SHIFT = $clog2(NUM_NODES);
  // arithmetic shift floors toward minus infinity
  assign fin0 = sum0 >>> SHIFT;
  assign fin1 = sum1 >>> SHIFT;
`else
  assign fin0 = sum0;
  assign fin1 = sum1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      cnt   <= '0;
      acc0  <= '0;
      acc1  <= '0;
      sc0   <= '0;
      sc1   <= '0;
      vld   <= 1'b0;
      cid   <= 1'b0;
      ovr   <= 1'b0;
      mis   <= 1'b0;
    end else begin
      if (one) begin
        mis <= 1'b1;
      end
      if (bus.clr) begin
        state <= ACCUM;
        cnt   <= '0;
        acc0  <= '0;
        acc1  <= '0;
        vld   <= 1'b0;
      end else begin
        unique case (state)
          ACCUM: begin
            if (pair) begin
              if (last) begin
                sc0   <= fin0;
                sc1   <= fin1;
                cid   <= (fin1 > fin0);
                acc0  <= '0;
                acc1  <= '0;
                cnt   <= '0;
                vld   <= 1'b1;
                state <= HOLD;
              end else begin
                acc0 <= sum0;
                acc1 <= sum1;
                cnt  <= cnt + CNT_W'(1);
              end
            end
          end
          HOLD: begin
            if (any) begin
              ovr <= 1'b1;
            end
            if (bus.class_ack) begin
              vld   <= 1'b0;
              state <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

  assign bus.class_valid  = vld;
  assign bus.class_id     = cid;
  assign bus.score0       = sc0;
  assign bus.score1       = sc1;
  assign bus.overrun      = ovr;
  assign bus.err_mismatch = mis;

endmodule

// File: tb/tb_graph_readout.sv
// Directed bench for graph_readout with a queue-based pooling model
// checked every cycle plus literal expectations per scenario.
module tb_graph_readout;

  localparam int N     = 4;
  localparam int IN_W  = 21;
  localparam int ACC_W = 24;

  logic clk;
  logic rst_n;

  graph_readout_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  graph_readout #(
    .NUM_NODES(N),
    .IN_W(IN_W),
    .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  bit started;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a graph is a list of node pairs; result is their sum (or floor mean)
  longint q0[$];
  longint q1[$];
  bit     m_valid;
  bit     m_id;
  longint m_s0;
  longint m_s1;
  bit     m_ovr;
  bit     m_err;

  function automatic longint pool(longint s);
`ifdef READOUT_MEAN_EN
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
`else
    return s;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_valid = 0;
      m_id    = 0;
      m_s0    = 0;
      m_s1    = 0;
      m_ovr   = 0;
      m_err   = 0;
    end else begin
      if (bus.in0_valid != bus.in1_valid) m_err = 1;
      if (bus.clr) begin
        q0.delete();
        q1.delete();
        m_valid = 0;
      end else if (m_valid) begin
        if (bus.in0_valid || bus.in1_valid) m_ovr = 1;
        if (bus.class_ack) m_valid = 0;
      end else if (bus.in0_valid && bus.in1_valid) begin
        q0.push_back(longint'(bus.in0));
        q1.push_back(longint'(bus.in1));
        if (q0.size() == N) begin
          longint t0;
          longint t1;
          t0 = 0;
          t1 = 0;
          foreach (q0[i]) t0 += q0[i];
          foreach (q1[i]) t1 += q1[i];
          m_s0    = pool(t0);
          m_s1    = pool(t1);
          m_id    = (m_s1 > m_s0);
          m_valid = 1;
          q0.delete();
          q1.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("valid", bus.class_valid, m_valid);
      chk("id", bus.class_id, m_id);
      chk("score0", bus.score0, m_s0);
      chk("score1", bus.score1, m_s1);
      chk("overrun", bus.overrun, m_ovr);
      chk("err", bus.err_mismatch, m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int a, int b);
    bus.in0       = IN_W'(a);
    bus.in1       = IN_W'(b);
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    cyc();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  task automatic ack();
    bus.class_ack = 1'b1;
    cyc();
    bus.class_ack = 1'b0;
  endtask

  task automatic lit(string name, int v, int id, longint s0, longint s1);
    chk({name, "_valid"}, bus.class_valid, v);
    chk({name, "_id"}, bus.class_id, id);
    chk({name, "_s0"}, bus.score0, s0);
    chk({name, "_s1"}, bus.score1, s1);
  endtask

`ifdef READOUT_MEAN_EN
  localparam bit MEAN = 1;
`else
  localparam bit MEAN = 0;
`endif

  initial begin
    tests = 0;
    fails = 0;
    started = 0;
    rst_n = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.clr = 1'b0;
    bus.class_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    started = 1;
    cyc();
    lit("reset", 0, 0, 0, 0);
    chk("reset_ovr", bus.overrun, 0);
    chk("reset_err", bus.err_mismatch, 0);

    send(10, -3); send(5, 7); send(-2, 4); send(1, 1);
    lit("mixed", 1, 0, MEAN ? 3 : 14, MEAN ? 2 : 9);
    ack();
    chk("ack_drop", bus.class_valid, 0);
    chk("ack_keep", bus.score0, MEAN ? 3 : 14);

    for (int i = 0; i < N; i++) send(-5, -5);
    lit("tie", 1, 0, MEAN ? -5 : -20, MEAN ? -5 : -20);
    ack();

    for (int i = 0; i < N; i++) send(1048575, -1048576);
    lit("maxw", 1, 0, MEAN ? 1048575 : 4194300,
        MEAN ? -1048576 : -4194304);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(100, 100);
      else cyc();
    end
    chk("ovr_set", bus.overrun, 1);
    lit("held", 1, 0, MEAN ? 1048575 : 4194300,
        MEAN ? -1048576 : -4194304);
    ack();
    chk("ovr_ack", bus.class_valid, 0);
    for (int i = 0; i < N; i++) send(1, 1);
    lit("fresh", 1, 0, MEAN ? 1 : 4, MEAN ? 1 : 4);
    ack();

    send(2, 1); send(2, 1);
    bus.in0 = IN_W'(50);
    bus.in0_valid = 1'b1;
    cyc();
    bus.in0_valid = 1'b0;
    chk("err_set", bus.err_mismatch, 1);
    chk("err_nores", bus.class_valid, 0);
    send(2, 1); send(2, 1);
    lit("mis", 1, 0, MEAN ? 2 : 8, MEAN ? 1 : 4);
    ack();

    send(2, 3); send(2, 2); send(0, 0); send(0, 0);
    lit("trunc", 1, MEAN ? 0 : 1, MEAN ? 1 : 4, MEAN ? 1 : 5);
    ack();

    send(9, 9); send(9, 9);
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    for (int i = 0; i < N; i++) send(1, 2);
    lit("clr", 1, 1, MEAN ? 1 : 4, MEAN ? 2 : 8);
    ack();

    send(9, 9); send(9, 9);
    rst_n = 1'b0;
    #1;
    lit("arst", 0, 0, 0, 0);
    chk("arst_ovr", bus.overrun, 0);
    chk("arst_err", bus.err_mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < N; i++) send(1, 2);
    lit("post_rst", 1, 1, MEAN ? 1 : 4, MEAN ? 2 : 8);
    ack();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
